// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl
//   Time-multiplexed scan controller for NDIG common-anode 7-segment digits that
//   share one BCD-to-7-segment decoder. Each digit is driven for PRESCALE cycles,
//   followed by GAP cycles with every anode off to avoid ghosting. New display
//   values land in a shadow register and are committed only at frame wrap.
//
//   Optional feature: define SEG7_LZB_EN to enable leading-zero blanking
//   (digit 0 is never blanked; a blanked digit still gets its anode slot).
//
// Ports
//   clk        : system clock, rising edge
//   rst_n      : synchronous active-low reset
//   en         : scan enable; 0 forces the display off
//   load       : strobe capturing value into the shadow register
//   value      : packed BCD, digit k at value[4k+3:4k]
//   dec_a      : BCD code to the shared decoder (4'hF = blank)
//   an         : active-low anode selects
//   pending    : shadow holds a value not yet committed
//   frame_done : one-cycle pulse at each frame wrap
module seg7_scan_ctrl #(
    parameter int unsigned NDIG     = 4,
    parameter int unsigned PRESCALE = 50000,
    parameter int unsigned GAP      = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                load,
    input  logic [4*NDIG-1:0]   value,
    output logic [3:0]          dec_a,
    output logic [NDIG-1:0]     an,
    output logic                pending,
    output logic                frame_done
);

    localparam int unsigned CMAX = (PRESCALE > GAP) ? PRESCALE : GAP;
    localparam int unsigned CW   = $clog2(CMAX);
    localparam int unsigned IW   = $clog2(NDIG);

    typedef enum logic [1:0] {StOff, StDrive, StGap} state_e;

    state_e              state_q;
    logic [CW-1:0]       cnt_q;
    logic [IW-1:0]       idx_q;
    logic [4*NDIG-1:0]   disp_q, disp_d;
    logic [4*NDIG-1:0]   shadow_q, shadow_d;
    logic                pending_q, pending_d;
    logic [NDIG-1:0]     an_q;
    logic [3:0]          dec_q;
    logic                frame_done_q;

    logic                gap_end;
    logic                wrap;
    logic [IW-1:0]       drive_idx;
    logic [NDIG-1:0]     blank;
    logic [3:0]          drive_code;
`ifdef SEG7_LZB_EN
    logic                zero_run;
`endif

    // Next-cycle buffer updates and the code for whichever digit is driven next.
    // drive_code is derived from disp_d so digit 0 of a new frame already shows
    // the value committed on that same edge.
    always_comb begin
        gap_end   = (state_q == StGap) && (cnt_q == CW'(GAP - 1)) && en;
        wrap      = gap_end && (idx_q == IW'(NDIG - 1));

        disp_d    = (wrap && pending_q) ? shadow_q : disp_q;
        shadow_d  = load ? value : shadow_q;
        pending_d = load ? 1'b1 : (wrap ? 1'b0 : pending_q);

        blank = '0;
`ifdef SEG7_LZB_EN
        zero_run = 1'b1;
        for (int k = NDIG - 1; k >= 1; k--) begin
            zero_run = zero_run && (disp_d[4*k +: 4] == 4'h0);
            blank[k] = zero_run;
        end
`endif

        if (state_q == StOff || wrap) begin
            drive_idx = '0;
        end else begin
            drive_idx = idx_q + IW'(1);
        end
        drive_code = blank[drive_idx] ? 4'hF : disp_d[{drive_idx, 2'b00} +: 4];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StOff;
            cnt_q        <= '0;
            idx_q        <= '0;
            disp_q       <= '1;
            shadow_q     <= '1;
            pending_q    <= 1'b0;
            an_q         <= '1;
            dec_q        <= 4'hF;
            frame_done_q <= 1'b0;
        end else begin
            disp_q       <= disp_d;
            shadow_q     <= shadow_d;
            pending_q    <= pending_d;
            frame_done_q <= 1'b0;
            if (!en) begin
                state_q <= StOff;
                cnt_q   <= '0;
                idx_q   <= '0;
                an_q    <= '1;
                dec_q   <= 4'hF;
            end else begin
                unique case (state_q)
                    StOff: begin
                        state_q <= StDrive;
                        cnt_q   <= '0;
                        idx_q   <= '0;
                        an_q    <= ~(NDIG'(1));
                        dec_q   <= drive_code;
                    end
                    StDrive: begin
                        if (cnt_q == CW'(PRESCALE - 1)) begin
                            state_q <= StGap;
                            cnt_q   <= '0;
                            an_q    <= '1;
                            dec_q   <= 4'hF;
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                    StGap: begin
                        if (gap_end) begin
                            state_q      <= StDrive;
                            cnt_q        <= '0;
                            idx_q        <= drive_idx;
                            an_q         <= ~(NDIG'(1) << drive_idx);
                            dec_q        <= drive_code;
                            frame_done_q <= wrap;
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                    default: begin
                        state_q <= StOff;
                        cnt_q   <= '0;
                        idx_q   <= '0;
                        an_q    <= '1;
                        dec_q   <= 4'hF;
                    end
                endcase
            end
        end
    end

    assign an         = an_q;
    assign dec_a      = dec_q;
    assign pending    = pending_q;
    assign frame_done = frame_done_q;

endmodule
